reg_rename_table: RTL and testbench

REG_RENAME_TABLE -- requirements
Module: reg_rename_table

---
 rtl/reg_rename_table.sv | 142 ++++++++++++++
 tb/tb_reg_rename_table.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_rename_table.sv
// reg_rename_table
//   Architectural-to-physical register map for an out-of-order core.
//   Holds 32 live entries (physical mapping plus ready bit) and NUM_CKPT
//   checkpoint copies used for branch mispredict recovery. Entry 0 is
//   hardwired to physical register 0 and is always ready.
//
// Ports
//   clock, reset          : clock; synchronous active-high reset
//   rs1_arch/rs2_arch     : source lookups -> rs*_preg, rs*_ready (combinational)
//   rename_valid/_rd/_new_preg : destination rename; rd_old_preg gives the
//                           mapping being replaced, for freelist return at commit
//   wb_valid/wb_preg      : WB_PORTS writeback wakeups, port k at [k*W +: W]
//   ckpt_save/_save_id    : snapshot the updated live table into a slot
//   ckpt_restore/_restore_id : reload the live table from a slot (wins
//                           over rename and save in the same cycle)
//
// Configuration
//   RENAME_WB_BYPASS_EN : when defined, same-cycle wakeups are forwarded
//                         onto rs1_ready/rs2_ready.
module reg_rename_table #(
  parameter int PHYS_ADDR_WIDTH = 7,
  parameter int NUM_CKPT        = 4,
  parameter int WB_PORTS        = 2,
  localparam int CKW            = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [4:0]                          rs1_arch,
  input  logic [4:0]                          rs2_arch,
  output logic [PHYS_ADDR_WIDTH-1:0]          rs1_preg,
  output logic [PHYS_ADDR_WIDTH-1:0]          rs2_preg,
  output logic                                rs1_ready,
  output logic                                rs2_ready,
  input  logic                                rename_valid,
  input  logic [4:0]                          rename_rd,
  input  logic [PHYS_ADDR_WIDTH-1:0]          rename_new_preg,
  output logic [PHYS_ADDR_WIDTH-1:0]          rd_old_preg,
  input  logic [WB_PORTS-1:0]                 wb_valid,
  input  logic [WB_PORTS*PHYS_ADDR_WIDTH-1:0] wb_preg,
  input  logic                                ckpt_save,
  input  logic [CKW-1:0]                      ckpt_save_id,
  input  logic                                ckpt_restore,
  input  logic [CKW-1:0]                      ckpt_restore_id
);

  localparam int W      = PHYS_ADDR_WIDTH;
  localparam int NPREGS = 1 << W;

  logic [W-1:0] r_map    [32];
  logic [31:0]  r_rdy;
  logic [W-1:0] r_ck_map [NUM_CKPT][32];
  logic [31:0]  r_ck_rdy [NUM_CKPT];

  logic [W-1:0] w_map_nxt    [32];
  logic [31:0]  w_rdy_nxt;
  logic [W-1:0] w_ck_map_nxt [NUM_CKPT][32];
  logic [31:0]  w_ck_rdy_nxt [NUM_CKPT];

  // One bit per physical register: set when any writeback port targets it.
  // Duplicate ports naturally collapse into a single wakeup.
  logic [NPREGS-1:0] w_wake;

  // NOTE: every variable written in an always_comb block gets a default
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_wake = '0;
    for (int k = 0; k < WB_PORTS; k++) begin
      if (wb_valid[k]) w_wake[wb_preg[k*W +: W]] = 1'b1;
    end
  end

  always_comb begin
    w_map_nxt    = r_map;
    w_rdy_nxt    = r_rdy;
    w_ck_map_nxt = r_ck_map;
    w_ck_rdy_nxt = r_ck_rdy;

    // Live table; entry 0 is never touched.
    for (int i = 1; i < 32; i++) begin
      if (ckpt_restore) begin
        w_map_nxt[i] = r_ck_map[ckpt_restore_id][i];
        w_rdy_nxt[i] = r_ck_rdy[ckpt_restore_id][i]
                     | w_wake[r_ck_map[ckpt_restore_id][i]];
      end else if (rename_valid && rename_rd == 5'(i)) begin
        // Rename beats a same-cycle wakeup of the old mapping.
        w_map_nxt[i] = rename_new_preg;
        w_rdy_nxt[i] = 1'b0;
      end else begin
        w_rdy_nxt[i] = r_rdy[i] | w_wake[r_map[i]];
      end
    end

    // Checkpoints keep receiving wakeups so a later restore sees them.
    for (int s = 0; s < NUM_CKPT; s++) begin
      for (int i = 1; i < 32; i++) begin
        w_ck_rdy_nxt[s][i] = r_ck_rdy[s][i] | w_wake[r_ck_map[s][i]];
      end
    end

    // A save captures the table as updated this cycle; restore discards it,
    // so a save/restore on the same slot leaves that slot's prior contents.
    if (ckpt_save && !ckpt_restore) begin
      w_ck_map_nxt[ckpt_save_id] = w_map_nxt;
      w_ck_rdy_nxt[ckpt_save_id] = w_rdy_nxt;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  // NOTE: the map and checkpoint arrays are reset on purpose: the identity
  // mapping is architectural state, not don't-care storage.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        r_map[i] <= W'(i);
        for (int s = 0; s < NUM_CKPT; s++) r_ck_map[s][i] <= W'(i);
      end
      r_rdy <= '1;
      for (int s = 0; s < NUM_CKPT; s++) r_ck_rdy[s] <= '1;
    end else begin
      r_map    <= w_map_nxt;
      r_rdy    <= w_rdy_nxt;
      r_ck_map <= w_ck_map_nxt;
      r_ck_rdy <= w_ck_rdy_nxt;
    end
  end

  // Lookups read pre-edge state. While reset is asserted the identity
  // values are forced so consumers never see stale mappings.
  assign rs1_preg    = reset ? W'(rs1_arch)  : r_map[rs1_arch];
  assign rs2_preg    = reset ? W'(rs2_arch)  : r_map[rs2_arch];
  assign rd_old_preg = reset ? W'(rename_rd) : r_map[rename_rd];

`ifdef RENAME_WB_BYPASS_EN
  assign rs1_ready = reset | r_rdy[rs1_arch] | w_wake[r_map[rs1_arch]];
  assign rs2_ready = reset | r_rdy[rs2_arch] | w_wake[r_map[rs2_arch]];
`else
  assign rs1_ready = reset | r_rdy[rs1_arch];
  assign rs2_ready = reset | r_rdy[rs2_arch];
`endif

endmodule

// File: tb/tb_reg_rename_table.sv
// Directed testbench for reg_rename_table with default parameters.
module tb_reg_rename_table;

  localparam int W = 7;

`ifdef RENAME_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset;
  logic [4:0]   rs1_arch, rs2_arch;
  logic [W-1:0] rs1_preg, rs2_preg;
  logic         rs1_ready, rs2_ready;
  logic         rename_valid;
  logic [4:0]   rename_rd;
  logic [W-1:0] rename_new_preg;
  logic [W-1:0] rd_old_preg;
  logic [1:0]   wb_valid;
  logic [2*W-1:0] wb_preg;
  logic         ckpt_save;
  logic [1:0]   ckpt_save_id;
  logic         ckpt_restore;
  logic [1:0]   ckpt_restore_id;

  int n_cmp = 0;
  int n_err = 0;

  reg_rename_table dut (
    .clock          (clock),
    .reset          (reset),
    .rs1_arch       (rs1_arch),
    .rs2_arch       (rs2_arch),
    .rs1_preg       (rs1_preg),
    .rs2_preg       (rs2_preg),
    .rs1_ready      (rs1_ready),
    .rs2_ready      (rs2_ready),
    .rename_valid   (rename_valid),
    .rename_rd      (rename_rd),
    .rename_new_preg(rename_new_preg),
    .rd_old_preg    (rd_old_preg),
    .wb_valid       (wb_valid),
    .wb_preg        (wb_preg),
    .ckpt_save      (ckpt_save),
    .ckpt_save_id   (ckpt_save_id),
    .ckpt_restore   (ckpt_restore),
    .ckpt_restore_id(ckpt_restore_id)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    rename_valid    = 1'b0;
    rename_rd       = '0;
    rename_new_preg = '0;
    wb_valid        = '0;
    wb_preg         = '0;
    ckpt_save       = 1'b0;
    ckpt_save_id    = '0;
    ckpt_restore    = 1'b0;
    ckpt_restore_id = '0;
  endtask

  // Advance one active edge; inputs change and outputs are sampled 2 ns later.
  task automatic tick();
    @(posedge clock);
    #2;
    idle();
    #1;
  endtask

  task automatic look(input logic [4:0] a1, input logic [4:0] a2);
    rs1_arch = a1;
    rs2_arch = a2;
    #1;
  endtask

  initial begin
    idle();
    reset    = 1'b1;
    rs1_arch = 5'd5;
    rs2_arch = 5'd31;
    #1;
    // Outputs are identity during reset, even before the first edge.
    check("rst_hold_preg", 32'(rs1_preg), 5);
    check("rst_hold_rdy", 32'(rs1_ready), 1);
    tick();
    tick();
    reset = 1'b0;
    #1;

    // After reset.
    look(5, 31);
    check("id5_preg", 32'(rs1_preg), 5);
    check("id5_rdy", 32'(rs1_ready), 1);
    check("id31_preg", 32'(rs2_preg), 31);
    check("id31_rdy", 32'(rs2_ready), 1);

    // Rename of x0 is ignored.
    rename_valid = 1'b1; rename_rd = 5'd0; rename_new_preg = 7'd99; #1;
    check("x0_old", 32'(rd_old_preg), 0);
    tick();
    look(0, 0);
    check("x0_preg", 32'(rs1_preg), 0);
    check("x0_rdy", 32'(rs1_ready), 1);

    // Rename rd=3 -> 40, then wake up 40.
    rename_valid = 1'b1; rename_rd = 5'd3; rename_new_preg = 7'd40; #1;
    check("r3_old", 32'(rd_old_preg), 3);
    tick();
    look(3, 0);
    check("r3_preg", 32'(rs1_preg), 40);
    check("r3_rdy0", 32'(rs1_ready), 0);
    wb_valid = 2'b01; wb_preg = {7'd0, 7'd40}; #1;
    check("r3_byp", 32'(rs1_ready), 32'(BYP));
    tick();
    check("r3_rdy1", 32'(rs1_ready), 1);

    // Save slot 1 alongside rename rd=7 -> 50; rename to 60; restore slot 1.
    rename_valid = 1'b1; rename_rd = 5'd7; rename_new_preg = 7'd50;
    ckpt_save = 1'b1; ckpt_save_id = 2'd1; #1;
    tick();
    look(7, 3);
    check("r7_preg50", 32'(rs1_preg), 50);
    rename_valid = 1'b1; rename_rd = 5'd7; rename_new_preg = 7'd60; #1;
    check("r7_old50", 32'(rd_old_preg), 50);
    tick();
    check("r7_preg60", 32'(rs1_preg), 60);
    ckpt_restore = 1'b1; ckpt_restore_id = 2'd1; #1;
    tick();
    check("rest1_preg", 32'(rs1_preg), 50);
    check("rest1_rdy", 32'(rs1_ready), 0);
    check("rest1_r3", 32'(rs2_preg), 40);
    check("rest1_r3rdy", 32'(rs2_ready), 1);

    // Save slot 2 with rd=9 -> 70 pending; dual-port wakeup of 70; restore.
    rename_valid = 1'b1; rename_rd = 5'd9; rename_new_preg = 7'd70;
    ckpt_save = 1'b1; ckpt_save_id = 2'd2; #1;
    tick();
    look(9, 0);
    check("r9_rdy0", 32'(rs1_ready), 0);
    wb_valid = 2'b11; wb_preg = {7'd70, 7'd70}; #1;
    check("r9_byp", 32'(rs1_ready), 32'(BYP));
    tick();
    check("r9_rdy1", 32'(rs1_ready), 1);
    rename_valid = 1'b1; rename_rd = 5'd9; rename_new_preg = 7'd71; #1;
    tick();
    check("r9_preg71", 32'(rs1_preg), 71);
    ckpt_restore = 1'b1; ckpt_restore_id = 2'd2; #1;
    tick();
    check("rest2_preg", 32'(rs1_preg), 70);
    check("rest2_rdy", 32'(rs1_ready), 1);

    // Restore + rename + save in one cycle: only restore happens.
    ckpt_restore = 1'b1; ckpt_restore_id = 2'd2;
    rename_valid = 1'b1; rename_rd = 5'd4; rename_new_preg = 7'd80;
    ckpt_save = 1'b1; ckpt_save_id = 2'd0; #1;
    tick();
    look(4, 9);
    check("pri_r4", 32'(rs1_preg), 4);
    check("pri_r9", 32'(rs2_preg), 70);
    ckpt_restore = 1'b1; ckpt_restore_id = 2'd0; #1;
    tick();
    check("slot0_r4", 32'(rs1_preg), 4);
    check("slot0_r9", 32'(rs2_preg), 9);
    check("slot0_r9rdy", 32'(rs2_ready), 1);

    // Rename rd=6 -> 90 while its old mapping (6) wakes up.
    rename_valid = 1'b1; rename_rd = 5'd6; rename_new_preg = 7'd90;
    wb_valid = 2'b10; wb_preg = {7'd6, 7'd0}; #1;
    check("r6_old", 32'(rd_old_preg), 6);
    tick();
    look(6, 0);
    check("r6_preg", 32'(rs1_preg), 90);
    check("r6_rdy", 32'(rs1_ready), 0);

    // Save and restore slot 1 together, with wakeup of 50.
    ckpt_restore = 1'b1; ckpt_restore_id = 2'd1;
    ckpt_save = 1'b1; ckpt_save_id = 2'd1;
    wb_valid = 2'b01; wb_preg = {7'd0, 7'd50}; #1;
    tick();
    look(7, 6);
    check("same_r7", 32'(rs1_preg), 50);
    check("same_r7rdy", 32'(rs1_ready), 1);
    check("same_r6", 32'(rs2_preg), 6);
    rename_valid = 1'b1; rename_rd = 5'd7; rename_new_preg = 7'd55; #1;
    tick();
    check("r7_preg55", 32'(rs1_preg), 55);
    ckpt_restore = 1'b1; ckpt_restore_id = 2'd1; #1;
    tick();
    check("slot1_r7", 32'(rs1_preg), 50);
    check("slot1_r7rdy", 32'(rs1_ready), 1);

    // Reset overrides a concurrent rename and clears checkpoints.
    reset = 1'b1;
    rename_valid = 1'b1; rename_rd = 5'd3; rename_new_preg = 7'd41; #1;
    check("rst2_hold", 32'(rs1_preg), 7);
    check("rst2_old", 32'(rd_old_preg), 3);
    tick();
    reset = 1'b0; #1;
    look(7, 3);
    check("rst2_r7", 32'(rs1_preg), 7);
    check("rst2_r3", 32'(rs2_preg), 3);
    ckpt_restore = 1'b1; ckpt_restore_id = 2'd1; #1;
    tick();
    check("rst2_ck_r7", 32'(rs1_preg), 7);
    check("rst2_ck_rdy", 32'(rs1_ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
